prince_sbox_cms_compress: RTL
=============================

Name: prince_sbox_cms_compress

Overview:
- Register-and-compress stage directly downstream of the PRINCE S-box CMS component functions (one 3rd-degree term per share combination, per S-box output bit).
- Stage 1 latches all raw component bits, unreduced, into a glitch-barrier register.
- Stage 2 XOR-compresses the registered components into NSHARE output shares per S-box bit and registers the result.
- Two-deep valid/ready pipeline, full throughput, feeding the next PRINCE round layer.

Parameters:
NBIT, 4, S-box output bits handled.
NCOMP, 16, component terms per S-box output bit.
NSHARE, 4, output shares per S-box bit; NCOMP must be a multiple of NSHARE (elaboration-time assertion).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  comp_in holds a valid component set.
in_ready  output  1  stage 1 can accept this cycle.
comp_in  input  NBIT*NCOMP  component bits; index b*NCOMP+c is component c of S-box bit b.
out_valid  output  1  share_out valid.
out_ready  input  1  downstream accepts share_out.
share_out  output  NBIT*NSHARE  compressed shares; index b*NSHARE+s is share s of S-box bit b.

Behaviour:
- Reset (rst_n low, asynchronous) clears s1_valid, s2_valid, all stage-1 and stage-2 data registers, share_out and out_valid to 0.
  - in_ready = 1 while reset is deasserted and the pipe is empty.
- Group size G = NCOMP/NSHARE.
  - share_out[b*NSHARE+s] = XOR of s1_data[b*NCOMP+c] for c in s*G .. s*G+G-1.
  - The compression is computed only from stage-1 register outputs, never from comp_in directly.
- Signals:
  - s2_free = !s2_valid || out_ready
  - in_ready = !s1_valid || s2_free (combinational, no dependence on in_valid)
  - accept = in_valid && in_ready
  - advance = s1_valid && s2_free
- Stage-1 data loads comp_in only on accept; otherwise it holds, with no toggling on idle or stall cycles. s1_valid next = accept || (s1_valid && !advance).
- Stage-2 data loads the compression result only on advance; otherwise it holds. s2_valid next = advance || (s2_valid && !out_ready).
- out_valid = s2_valid; share_out = stage-2 data register.
- Latency: comp_in accepted at edge N appears on share_out with out_valid high after edge N+1 (2 register stages). Throughput is 1 set/cycle when out_ready stays high.
- Stall: with out_ready low and both stages full, in_ready = 0. Data in both stages holds bit-exact. No beat is dropped or duplicated.
- Simultaneous events: if out_ready is high while both stages are full, stage 2 takes stage 1 and stage 1 takes the new input in the same edge.
- out_valid, once high, stays high with stable share_out until out_ready is sampled high.
- Reset mid-operation flushes both stages immediately. Any in-flight beats are discarded and no spurious out_valid appears after reset release.
- No data-path logic crosses between components of different S-box bits.

Test Plan:
- Reset: rst_n low, then released with in_valid=0 -> out_valid=0, share_out=0, in_ready=1.
- Single beat: comp_in bit-0 group = 16'hA5C3 (bits 0..15 of S-box bit 0), others 0, in_valid for 1 cycle, out_ready=1.
  - Expected 2 edges later: share_out[3:0] = {XOR(4'hA)=0, XOR(4'h5)=0, XOR(4'hC)=0, XOR(4'h3)=0} = 4'h0.
  - Then repeat with 16'h0001 -> share_out[0]=1 and all other bits 0, both one cycle later than the first result.
- Streaming: 64 random comp_in sets back-to-back with out_ready=1 -> in_ready constantly 1, out_valid high from cycle 2 on, every share matching the software XOR model in order.
- Backpressure: out_ready low for 5 cycles while in_valid stays high.
  - in_ready drops after 2 accepts; share_out stays stable.
  - Stage-1 register shows no toggles (checked with a toggle counter).
  - On out_ready high, the order is preserved with no loss or duplication.
- Reset mid-stream: rst_n asserted asynchronously between clock edges with both stages full -> out_valid and data go to 0 at once, and no residual beat emerges after release.
- Random stress: random in_valid/out_ready at 50 % for 10k cycles -> a scoreboard sees every accepted set exactly once in order. Protocol assertions check stable share_out while out_valid && !out_ready.

Source files
------------

// File: rtl/prince_sbox_cms_compress_if.sv
// Handshake bundle between the PRINCE S-box CMS component stage, this
// register-and-compress stage, and the next round layer.
interface prince_sbox_cms_compress_if #(
  parameter int NBIT   = 4,
  parameter int NCOMP  = 16,
  parameter int NSHARE = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NBIT*NCOMP-1:0]    comp_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [NBIT*NSHARE-1:0]   share_out;

  // Producer of component sets / consumer of compressed shares.
  modport master (
    output in_valid,
    output comp_in,
    input  in_ready,
    input  out_valid,
    input  share_out,
    output out_ready
  );

  // The compress stage itself.
  modport slave (
    input  in_valid,
    input  comp_in,
    output in_ready,
    output out_valid,
    input  out_ready,
    output share_out
  );
endinterface

// File: rtl/prince_sbox_cms_compress.sv
// PRINCE S-box CMS register-and-compress stage.
// Stage 1 registers the raw 3rd-degree component terms unreduced (glitch
// barrier); stage 2 XOR-folds each group of NCOMP/NSHARE registered terms
// into one output share and registers it. Two-deep valid/ready pipe.
module prince_sbox_cms_compress #(
  parameter int NBIT   = 4,
  parameter int NCOMP  = 16,
  parameter int NSHARE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  prince_sbox_cms_compress_if.slave bus
);

  localparam int G = NCOMP / NSHARE;

  if ((NCOMP % NSHARE) != 0) begin : g_bad_share_count
    $error("prince_sbox_cms_compress: NCOMP must be a multiple of NSHARE");
  end

  logic                     s1_valid;
  logic                     s2_valid;
  logic                     s2_free;
  logic                     accept;
  logic                     advance;
  logic [NBIT*NCOMP-1:0]    s1_data;
  logic [NBIT*NSHARE-1:0]   s2_data;
  logic [NBIT*NSHARE-1:0]   comp_xor;

  // Handshake: stage 1 may load whenever it is empty or can move into stage 2.
  always_comb begin
    s2_free      = !s2_valid || bus.out_ready;
    bus.in_ready = !s1_valid || s2_free;
    accept       = bus.in_valid && bus.in_ready;
    advance      = s1_valid && s2_free;
  end

  // Compression reads only the stage-1 register, never comp_in, and each
  // share folds terms belonging to a single S-box bit.
  for (genvar b = 0; b < NBIT; b++) begin : g_bit
    for (genvar s = 0; s < NSHARE; s++) begin : g_share
      assign comp_xor[b*NSHARE+s] = ^s1_data[b*NCOMP+s*G +: G];
    end
  end

  // Stage 1: latch raw components on accept, otherwise hold bit-exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept || (s1_valid && !advance);
      if (accept) begin
        s1_data <= bus.comp_in;
      end
    end
  end

  // Stage 2: register compressed shares on advance, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= advance || (s2_valid && !bus.out_ready);
      if (advance) begin
        s2_data <= comp_xor;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.share_out = s2_data;

endmodule
